// File: rtl/fxp_pkg.sv
// Shared signed fixed-point helpers for the matrix pipeline stages
// (transpose, multiply, and the later add/invert stages).
package fxp_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Working width for saturation; must cover the widest accumulator in use.
  localparam int SAT_W = 128;

  // Accumulator width that cannot overflow over an N-term dot product.
  function automatic int acc_width(input int dw, input int n);
    return 2*dw + $clog2(n) + 1;
  endfunction

  localparam int ACC_WIDTH = acc_width(32, 3);

  // Flat row-major element index of (r,c) in an n x n matrix.
  function automatic int mat_idx(input int r, input int c, input int n);
    return r*n + c;
  endfunction

  // Clamp a sign-extended value into the signed range of dw bits.
  // The caller keeps the low dw bits of the result.
  function automatic logic signed [SAT_W-1:0] fxp_sat(input logic signed [SAT_W-1:0] v,
                                                      input int dw);
    logic signed [SAT_W-1:0] mx;
    logic signed [SAT_W-1:0] mn;
    mx = (SAT_W'(1) << (dw-1)) - SAT_W'(1);
    mn = ~mx;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Registered signed multiply-accumulate with synchronous clear. The scaled
// output q reflects acc + a*b, so the final term of a dot product can be
// written out on the same edge that clears the accumulator.
module fxp_mac
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16,
  parameter int ACC_W      = ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic        [DATA_WIDTH-1:0] q
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        sum;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [SAT_W-1:0]        sat_full;
  logic                           unused_sat;

  assign prod     = a * b;
  assign sum      = acc + {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  // Arithmetic shift floors toward -inf before saturation.
  assign shifted  = sum >>> BIN_POS;
  assign sat_full = fxp_sat({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, DATA_WIDTH);
  assign q        = sat_full[DATA_WIDTH-1:0];
  assign unused_sat = ^sat_full[SAT_W-1:DATA_WIDTH];

  // Accumulator: clear has priority over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential fixed-point N x N matrix multiply, one MAC per cycle.
// Operands are latched at acceptance; C is filled row-major and flagged
// valid only once every element has been written.
module matmul_seq
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     b,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     c
);

  localparam int N     = MATRIX_SIZE;
  localparam int NN    = N*N;
  localparam int IW    = (N  > 1) ? $clog2(N)  : 1;
  localparam int XW    = (NN > 1) ? $clog2(NN) : 1;
  localparam int ACC_W = acc_width(DATA_WIDTH, N);

  state_t state, state_nx;

  logic [NN-1:0][DATA_WIDTH-1:0] a_q, b_q, c_q;
  logic [IW-1:0]                 i, j, k;
  logic [XW-1:0]                 aidx, bidx, cidx;
  logic [DATA_WIDTH-1:0]         q;
  logic                          accept, calc, last_k, last_j, last_i, last;

  assign accept = in_valid && in_ready;
  assign calc   = (state == CALC);
  assign last_k = (k == IW'(N-1));
  assign last_j = (j == IW'(N-1));
  assign last_i = (i == IW'(N-1));
  assign last   = last_k && last_j && last_i;

  assign aidx = XW'(mat_idx(int'(i), int'(k), N));
  assign bidx = XW'(mat_idx(int'(k), int'(j), N));
  assign cidx = XW'(mat_idx(int'(i), int'(j), N));

  assign c = c_q;

  fxp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIN_POS    (BIN_POS),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || (calc && last_k)),
    .en    (calc),
    .a     (a_q[aidx]),
    .b     (b_q[bidx]),
    .q     (q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, row-major index walk and result writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (calc) begin
      if (last_k) begin
        c_q[cidx] <= q;
        k <= '0;
        if (last_j) begin
          j <= '0;
          i <= last_i ? '0 : i + IW'(1);
        end else begin
          j <= j + IW'(1);
        end
      end else begin
        k <= k + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq (N=3, 32-bit, 16 fractional bits).
module tb_matmul_seq;

  localparam int N  = 3;
  localparam int NN = N*N;
  localparam int DW = 32;

  typedef logic [NN-1:0][DW-1:0] mat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  mat_t a = '0;
  mat_t b = '0;
  mat_t c;

  int tests = 0;
  int fails = 0;

  matmul_seq #(.DATA_WIDTH(DW), .BIN_POS(16), .MATRIX_SIZE(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NN*DW-1:0] obs, input logic [NN*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mat_t diag(input logic [DW-1:0] v);
    mat_t m = '0;
    for (int r = 0; r < N; r++) m[r*N+r] = v;
    return m;
  endfunction

  function automatic mat_t fill(input logic [DW-1:0] v);
    mat_t m;
    for (int e = 0; e < NN; e++) m[e] = v;
    return m;
  endfunction

  function automatic mat_t one(input logic [DW-1:0] v);
    mat_t m = '0;
    m[0] = v;
    return m;
  endfunction

  // Present an operand pair for one edge and wait for out_valid; checks latency.
  task automatic start_and_wait(input string tag, input mat_t x, input mat_t y);
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, in_ready, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 27);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  task automatic run(input string tag, input mat_t x, input mat_t y, input mat_t exp);
    start_and_wait(tag, x, y);
    chk({tag, "_c"}, c, exp);
    handshake(tag);
    chk({tag, "_c_hold"}, c, exp);
  endtask

  initial begin
    mat_t rb, ea, ec;

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c", c, '0);
    #12;
    rst_n = 1'b1;
    tick();

    // Identity times random B within +-10.0
    for (int e = 0; e < NN; e++)
      rb[e] = DW'($urandom_range(0, 20*65536)) - DW'(10*65536);
    run("ident", diag(32'h0001_0000), rb, rb);

    // Uniform 2.0 x 1.5 over 3 terms = 9.0
    run("uniform", fill(32'h0002_0000), fill(32'h0001_8000), fill(32'h0009_0000));

    // Sign and floor truncation
    run("neg", one(32'hFFFE_8000), one(32'h0002_0000), one(32'hFFFD_0000));
    run("floor", one(32'hFFFF_FFFF), one(32'h0000_8000), one(32'hFFFF_FFFF));
    run("trunc0", one(32'h0000_0001), one(32'h0000_8000), one(32'h0000_0000));

    // Saturation both ways
    run("sat_pos", diag(32'h00C8_0000), diag(32'h00C8_0000), diag(32'h7FFF_FFFF));
    ea = diag(32'hFF38_0000);
    ec = diag(32'h8000_0000);
    start_and_wait("sat_neg", ea, diag(32'h00C8_0000));
    chk("sat_neg_c", c, ec);

    // Backpressure in DONE with a stray in_valid pulse
    for (int t = 0; t < 10; t++) begin
      in_valid = (t == 3);
      a = fill(32'h0001_0000);
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_c", c, ec);
    end
    in_valid = 1'b0;
    handshake("bp");
    chk("bp_c_after", c, ec);
    tick();
    chk("bp_no_start", in_ready, 1'b1);

    // Reset in the middle of CALC, then a clean rerun
    a = fill(32'h0002_0000);
    b = fill(32'h0001_8000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("mid_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_c", c, '0);
    #3;
    rst_n = 1'b1;
    tick();
    run("rerun", fill(32'h0002_0000), fill(32'h0001_8000), fill(32'h0009_0000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequential signed fixed-point N×N matrix multiplier: C = A·B.
- Sits directly downstream of the combinational transpose stage. Typical use: A = P, B = Pᵀ for covariance products in the navigation filter.
- Uses the same flattened matrix bus format as the transpose stage.
- Performs one multiply-accumulate (MAC) per cycle, with a valid/ready handshake on both input and output.

Parameters:
- DATA_WIDTH, 32, element width in bits; signed two's complement.
- BIN_POS, 16, number of fractional bits (binary point position).
- MATRIX_SIZE, 3, N; matrices are N×N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a and b are valid.
- in_ready  output  1  block can accept a new operand pair.
- a  input  N*N*DATA_WIDTH  left operand; element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- b  input  N*N*DATA_WIDTH  right operand; same element layout as a.
- out_valid  output  1  c holds a completed product.
- out_ready  input  1  consumer accepts c.
- c  output  N*N*DATA_WIDTH  product matrix; same element layout.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - rst_n is asynchronous assert, active-low, and takes effect immediately.
  - Reset values: state=IDLE, out_valid=0, c=0, all index counters=0, accumulator=0.
  - in_ready = (state==IDLE), decoded combinationally, so it reads 1 during and after reset.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: latch a and b into internal registers, clear i, j, k and the accumulator, go to CALC.
  - CALC:
    - Each cycle: acc += A[i][k]*B[k][j], using a 2*DATA_WIDTH-bit signed product.
    - The accumulator is 2*DATA_WIDTH+clog2(N)+1 bits wide, so accumulation never overflows.
    - When k==N-1: write the scaled element to C[i][j], clear acc, set k=0, and advance j, then i (row-major order).
    - After the final element (i=j=k=N-1): go to DONE.
    - The a and b ports are ignored during CALC.
  - DONE:
    - out_valid=1.
    - On out_ready: go to IDLE and drop out_valid on the same edge.
- Scaling of each result element:
  - Arithmetic right shift of the full sum by BIN_POS, i.e. truncation toward −∞.
  - Then saturate to DATA_WIDTH bits: max 0x7F…F, min 0x80…0.
- Latency:
  - Acceptance occurs at rising edge t0.
  - out_valid=1 after edge t0+N³; for N=3 that is 27 cycles of CALC.
- Throughput:
  - One operation per N³+2 cycles, with out_ready held high.
  - There is no overlap between operations: in_ready=0 in CALC and DONE.
- Output stability:
  - c changes only during CALC writes.
  - c is stable for the whole of DONE and holds its last result after the handshake, until the next operation overwrites it.
  - Individual elements of c update progressively during CALC; consumers must read c only when out_valid=1.
- Backpressure: if out_ready=0, remain in DONE indefinitely; c and out_valid are held.
- Simultaneous events: in_valid asserted during CALC or DONE is not accepted and has no effect.
- Reset mid-operation: aborts immediately to IDLE with out_valid=0 and c=0. No partial result is ever flagged valid.
- BIN_POS=0 is legal and gives pure integer multiply.
- N=1 is legal: exactly 1 CALC cycle.

Decomposition:
- Package fxp_pkg:
  - function fxp_sat(wide value, DATA_WIDTH) → saturated element.
  - function mat_idx(r, c, N) → flat element index.
  - localparam ACC_WIDTH, derived from DATA_WIDTH and N.
  - State enum {IDLE, CALC, DONE}.
  - fxp_pkg is shared with the transpose and future add/invert stages.
- Sub-module fxp_mac:
  - Registered signed multiply-accumulate with clear, plus a combinational shift+saturate output.
  - Reusable by the later matrix-vector stage.

Test Plan:
All scenarios use N=3, DATA_WIDTH=32, BIN_POS=16.
- Identity: A = identity (diagonal 0x00010000), B = random values within ±10.0 → c equals b bit-exactly; out_valid rises exactly 27 cycles after acceptance.
- Uniform values: every element of A = 0x00020000 (2.0), every element of B = 0x00018000 (1.5) → every element of c = 0x00090000 (9.0).
- Sign and truncation:
  - A[0][0] = 0xFFFE8000 (−1.5), B[0][0] = 0x00020000, all other elements 0 → C[0][0] = 0xFFFD0000 (−3.0).
  - A[0][0] = 0xFFFFFFFF, B[0][0] = 0x00008000 → C[0][0] = 0xFFFFFFFF (floor).
  - A[0][0] = 0x00000001, B[0][0] = 0x00008000 → C[0][0] = 0.
- Saturation:
  - A and B diagonal = 0x00C80000 (200.0) → C diagonal = 0x7FFFFFFF, off-diagonal = 0.
  - Negating A's diagonal → C diagonal = 0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, c is unchanged, in_ready stays 0, and an in_valid pulse during DONE is ignored. After out_ready=1 → IDLE on the next edge.
- Reset mid-CALC: assert rst_n=0 at cycle 10 of CALC → out_valid=0, c=0, in_ready=1 immediately. After release, a new operation produces the correct result.
